// File: rtl/sumdiff_seq.sv
// rtl/sumdiff_seq.sv - sequential (A+B)-(C+D) on one shared 6-bit add/sub unit
//
// Purpose: accepts four 4-bit unsigned operands on a start pulse and computes
//   F = (A+B)-(C+D) as a 6-bit two's complement value over three FSM steps.
//   The same adder/subtractor is reused for each step.
// Optional feature: define SUMDIFF_CLAMP5_EN to saturate F to -16..+15 and
//   report saturation on ovf; without it F is unclamped and ovf stays 0.
// Ports:
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   start       request pulse; operands sampled with it while idle
//   A,B,C,D     4-bit unsigned operands
//   busy        high from the cycle after acceptance through DONE
//   done        one-cycle pulse when F is valid
//   F           6-bit signed result, held until the next DIFF step
//   ovf         saturation flag, held together with F
module sumdiff_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic [3:0] C,
  input  logic [3:0] D,
  output logic       busy,
  output logic       done,
  output logic [5:0] F,
  output logic       ovf
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SUM_AB = 3'd1,
    SUM_CD = 3'd2,
    DIFF   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic [5:0] s1_q, s1_d, s2_q, s2_d;
  logic [5:0] f_q, f_d;
  logic       ovf_q, ovf_d;

  // Shared adder/subtractor: subtraction is x + ~y + 1.
  logic [5:0] alu_x, alu_y, alu_r;
  logic       alu_sub;

  assign alu_r = alu_x + (alu_y ^ {6{alu_sub}}) + {5'b0, alu_sub};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    d_d     = d_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    f_d     = f_q;
    ovf_d   = ovf_q;
    alu_x   = 6'd0;
    alu_y   = 6'd0;
    alu_sub = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = C;
          d_d     = D;
          state_d = SUM_AB;
        end
      end
      SUM_AB: begin
        alu_x   = {2'b00, a_q};
        alu_y   = {2'b00, b_q};
        s1_d    = alu_r;
        state_d = SUM_CD;
      end
      SUM_CD: begin
        alu_x   = {2'b00, c_q};
        alu_y   = {2'b00, d_q};
        s2_d    = alu_r;
        state_d = DIFF;
      end
      DIFF: begin
        alu_x   = s1_q;
        alu_y   = s2_q;
        alu_sub = 1'b1;
`ifdef SUMDIFF_CLAMP5_EN
        // Top two bits 01 means +16..+30, 10 means -17..-30: outside 5-bit range.
        if (alu_r[5:4] == 2'b01) begin
          f_d   = 6'b001111;
          ovf_d = 1'b1;
        end else if (alu_r[5:4] == 2'b10) begin
          f_d   = 6'b110000;
          ovf_d = 1'b1;
        end else begin
          f_d   = alu_r;
          ovf_d = 1'b0;
        end
`else
        f_d     = alu_r;
        ovf_d   = 1'b0;
`endif
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= 4'd0;
      b_q     <= 4'd0;
      c_q     <= 4'd0;
      d_q     <= 4'd0;
      s1_q    <= 6'd0;
      s2_q    <= 6'd0;
      f_q     <= 6'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      d_q     <= d_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      f_q     <= f_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign F    = f_q;
  assign ovf  = ovf_q;

endmodule

// File: doc/sumdiff_seq.md
SUMDIFF_SEQ -- requirements
Module: sumdiff_seq

Interface
REQ-001 Parameter: none; all widths fixed (operands 4-bit unsigned, result 6-bit two's complement).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 start  input  1  request pulse; operands sampled with it.
REQ-005 A, B, C, D  input  4 each  unsigned operands.
REQ-006 busy  output  1  high while a computation is in progress.
REQ-007 done  output  1  one-cycle pulse: F valid.
REQ-008 F  output  6  signed result (A+B)-(C+D), range -30..+30.
REQ-009 ovf  output  1  clamp indicator (see Configuration).

Function
REQ-010 Block SHALL compute (A+B)-(C+D) using exactly one shared 6-bit adder/subtractor, time-multiplexed by an FSM.
REQ-011 States SHALL be IDLE, SUM_AB, SUM_CD, DIFF, DONE.
REQ-012 IDLE: on start=1, latch A,B,C,D into operand registers and go to SUM_AB; start=0 stays in IDLE.
REQ-013 SUM_AB: accumulator s1 <= A+B (zero-extended); go to SUM_CD.
REQ-014 SUM_CD: register s2 <= C+D; go to DIFF.
REQ-015 DIFF: F <= s1-s2 (6-bit two's complement); go to DONE.
REQ-016 DONE: done=1 for this one cycle; go to IDLE unconditionally.
REQ-017 Latency: done SHALL be high in the 4th cycle after the edge that samples start.
REQ-018 busy SHALL be 1 in SUM_AB, SUM_CD, DIFF and DONE; 0 in IDLE.
REQ-019 start while busy=1 SHALL be ignored; no queuing. Minimum request spacing: 5 cycles.
REQ-020 Operand changes after the accepting edge SHALL NOT affect the in-flight result.
REQ-021 F SHALL hold its value from DONE until the next DIFF update.
REQ-022 No intermediate sum SHALL overflow: s1, s2 in 0..30, fit 6 bits.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force state IDLE, busy=0, done=0, F=0, ovf=0, and clear operand, s1 and s2 registers.
REQ-024 Reset mid-operation SHALL abort it; no done pulse for the aborted request.
REQ-025 start sampled in the same cycle as rst_n=0 SHALL be ignored.

Configuration
REQ-026 Macro SUMDIFF_CLAMP5_EN.
REQ-027 Defined: F SHALL be saturated to the 5-bit signed range -16..+15, sign-extended to 6 bits. ovf=1 in the DONE cycle, and held with F, when saturation occurred; otherwise ovf=0.
REQ-028 Undefined: F SHALL be the unclamped 6-bit result, and ovf SHALL be tied 0.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles while start=1, then release. Required: busy=0, done=0, F=0, ovf=0, no computation started.
REQ-030 A=11,B=12,C=9,D=7 with a start pulse. Required: done exactly 4 cycles later, F=+7, ovf=0. Back-to-back run A=14,B=14,C=13,D=11 gives F=+4.
REQ-031 Operand isolation: A=14,B=8,C=0,D=8, start, then all operands changed to 0 on the next cycle. Required: F=+14. A start pulse issued while busy=1 produces no additional done.
REQ-032 Extremes: A=B=0,C=D=15 and A=B=15,C=D=0.
  - Without the macro: F=-30 (6'b100010) and F=+30.
  - With SUMDIFF_CLAMP5_EN: F=-16 and F=+15, each with ovf=1.
REQ-033 Abort: A=15,B=15,C=9,D=11, start; assert rst_n=0 in the SUM_CD cycle. Required: no done pulse, F=0. A new request after release computes F=+10 normally.
